// File: rtl/crypt_unpacker.sv
// Receive-side unpacker: header byte, LSB-first ciphertext bytes, engine handoff, LSB-first plaintext bits.
// Optional header range check: define CRYPT_UNPACKER_HDR_CHECK_EN.
module crypt_unpacker #(
  parameter int unsigned WORD_W  = 32,
  parameter int unsigned BYTES_W = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic              start,
  input  logic [7:0]        rx_data,
  input  logic              rx_valid,
  output logic              fme_start,
  output logic [WORD_W-1:0] fme_base,
  input  logic [WORD_W-1:0] fme_result,
  input  logic              fme_done,
  output logic              bit_out,
  output logic              bit_valid,
  input  logic              bit_ready,
  output logic [5:0]        n_len,
  output logic              busy,
  output logic              overrun,
  output logic              hdr_err
);

  localparam int unsigned CNT_W = 6;
  localparam logic [BYTES_W-1:0] LAST_BYTE = BYTES_W'(WORD_W / 8 - 1);
  localparam logic [7:0] WORD_W_B = 8'(WORD_W);

  typedef enum logic [2:0] {IDLE, HEADER, COLLECT, DECRYPT, EMIT} state_t;

  state_t             state;
  logic [BYTES_W-1:0] byte_cnt;
  logic [CNT_W-1:0]   bit_cnt;
  logic [WORD_W-1:0]  shift_reg;
  logic [BYTES_W+2:0] byte_lsb;
  logic               last_bit;

  assign byte_lsb = {byte_cnt, 3'b000};
  // Payload is n_len-1 bits; true on the handshake that moves the final one.
  assign last_bit = (CNT_W'(bit_cnt + 6'd1) == CNT_W'(n_len - 6'd1));

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      byte_cnt  <= '0;
      bit_cnt   <= '0;
      shift_reg <= '0;
      fme_base  <= '0;
      fme_start <= 1'b0;
      bit_out   <= 1'b0;
      bit_valid <= 1'b0;
      n_len     <= '0;
      busy      <= 1'b0;
      overrun   <= 1'b0;
      hdr_err   <= 1'b0;
    end else if (!en) begin
      // Disable wins over every other event; any in-flight engine result is abandoned.
      if (state == IDLE && start) begin
        overrun <= 1'b0;
        hdr_err <= 1'b0;
      end
      state     <= IDLE;
      busy      <= 1'b0;
      fme_start <= 1'b0;
      bit_valid <= 1'b0;
      byte_cnt  <= '0;
      fme_base  <= '0;
    end else begin
      fme_start <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            state   <= HEADER;
            busy    <= 1'b1;
            overrun <= 1'b0;
            hdr_err <= 1'b0;
          end
        end
        HEADER: begin
          if (rx_valid) begin
`ifdef CRYPT_UNPACKER_HDR_CHECK_EN
            if (rx_data < 8'd2 || rx_data > WORD_W_B) begin
              hdr_err <= 1'b1;
              state   <= IDLE;
              busy    <= 1'b0;
            end else begin
              n_len    <= 6'(rx_data);
              state    <= COLLECT;
              byte_cnt <= '0;
              fme_base <= '0;
            end
`else
            n_len    <= (rx_data > WORD_W_B) ? 6'(WORD_W) : 6'(rx_data);
            state    <= COLLECT;
            byte_cnt <= '0;
            fme_base <= '0;
`endif
          end
        end
        COLLECT: begin
          if (rx_valid) begin
            fme_base[byte_lsb +: 8] <= rx_data;
            if (byte_cnt == LAST_BYTE) begin
              byte_cnt  <= '0;
              state     <= DECRYPT;
              fme_start <= 1'b1;
            end else begin
              byte_cnt <= BYTES_W'(byte_cnt + 1'b1);
            end
          end
        end
        DECRYPT: begin
          if (rx_valid) overrun <= 1'b1;
          if (fme_done) begin
            if (n_len <= 6'd1) begin
              state    <= COLLECT;
              byte_cnt <= '0;
              fme_base <= '0;
            end else begin
              shift_reg <= fme_result;
              bit_cnt   <= '0;
              bit_out   <= fme_result[0];
              bit_valid <= 1'b1;
              state     <= EMIT;
            end
          end
        end
        EMIT: begin
          if (rx_valid) overrun <= 1'b1;
          if (bit_valid && bit_ready) begin
            shift_reg <= shift_reg >> 1;
            bit_cnt   <= CNT_W'(bit_cnt + 6'd1);
            if (last_bit) begin
              bit_valid <= 1'b0;
              state     <= COLLECT;
              byte_cnt  <= '0;
              fme_base  <= '0;
            end else begin
              bit_out <= shift_reg[1];
            end
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule
